weights_save: RTL and testbench
===============================

WEIGHTS_SAVE -- requirements
Module: weights_save

Interface
REQ-001: Parameter WIDTH, default 8, bits per weight word.
REQ-002: Parameter ROWS, default 1, number of weight rows.
REQ-003: Parameter COLS, default 8, weights per row; DEPTH = ROWS*COLS, AW = max(1, clog2(DEPTH)).
REQ-004: clk  input  1  single clock, all logic on rising edge.
REQ-005: rst_n  input  1  asynchronous active-low reset.
REQ-006: start  input  1  begin a capture; sampled only in IDLE.
REQ-007: s_data  input  WIDTH  incoming weight word.
REQ-008: s_valid  input  1  s_data valid.
REQ-009: s_last  input  1  marks final word of frame.
REQ-010: s_ready  output  1  block accepts a word this cycle.
REQ-011: wr_en  output  1  RAM write strobe.
REQ-012: wr_addr  output  AW  RAM write address, row-major (row*COLS+col).
REQ-013: wr_data  output  WIDTH  RAM write data.
REQ-014: count  output  AW+1  words accepted in current/last frame.
REQ-015: busy  output  1  high in CAPTURE.
REQ-016: done  output  1  one-cycle completion pulse.
REQ-017: err  output  1  sticky frame-length error.

Function
REQ-018: FSM states IDLE, CAPTURE, DONE; IDLE after reset.
REQ-019: IDLE: s_ready=0; start=1 -> CAPTURE next cycle, count<=0, err<=0.
REQ-020: CAPTURE: s_ready=1, busy=1; handshake = s_valid & s_ready.
REQ-021: Each handshake registers wr_en=1, wr_addr=count, wr_data=s_data on the next cycle (1-cycle latency), count increments by 1.
REQ-022: wr_en is 0 on every cycle not following a handshake; wr_addr/wr_data hold last values.
REQ-023: Handshake with s_last=1 and count==DEPTH-1 -> DONE, err stays 0.
REQ-024: Handshake with s_last=1 and count<DEPTH-1 (short frame) -> DONE, err<=1; word is still written.
REQ-025: Handshake with s_last=0 and count==DEPTH-1 (long frame) -> DONE, err<=1; word written, further words not accepted.
REQ-026: s_ready is 0 in the cycle after the terminating handshake; no write beyond address DEPTH-1 ever occurs.
REQ-027: DONE: done=1 for exactly one cycle, s_ready=0, then IDLE.
REQ-028: start outside IDLE is ignored; start held high in IDLE after DONE starts a new frame.
REQ-029: count and err hold their final values in IDLE until the next accepted start.
REQ-030: s_valid low in CAPTURE stalls with no state change (no timeout).

Reset
REQ-031: rst_n low asynchronously forces IDLE, s_ready=0, wr_en=0, wr_addr=0, wr_data=0, count=0, busy=0, done=0, err=0.
REQ-032: Reset mid-CAPTURE abandons the frame; no write strobe is produced on or after the reset edge; RAM contents are not cleared.
REQ-033: After rst_n deasserts, no capture begins until a start is seen in IDLE.

Verification
REQ-034: Normal frame: start, then 8 words 0x10..0x17 with s_last on 0x17, s_valid always 1 -> wr_en on 8 consecutive cycles, addr 0..7 data 0x10..0x17, done one cycle, err=0, count=8.
REQ-035: Stalls: same frame with s_valid low every other cycle -> identical write sequence, done once, err=0.
REQ-036: Short frame: s_last on 5th word (0xA4) -> 5 writes addr 0..4, done, err=1, count=5.
REQ-037: Long frame: 9 words, no s_last -> 8 writes addr 0..7, s_ready=0 after 8th, 9th word not written, err=1, count=8.
REQ-038: Reset mid-frame: rst_n low after 3 words -> outputs to reset values immediately, no further wr_en; subsequent normal frame behaves as REQ-034.
REQ-039: Start while busy, then back-to-back frames with start held -> mid-frame start ignored; second frame begins in the cycle after done, err cleared.

Source files
------------

// File: rtl/weights_save.sv
// Streams weight words into a row-major RAM image through a registered write port (1-cycle latency).
// s_ready is high only while capturing; a frame ends on s_last or on the final address.
module weights_save #(
  parameter  int WIDTH = 8,
  parameter  int ROWS  = 1,
  parameter  int COLS  = 8,
  localparam int DEPTH = ROWS * COLS,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  state_t state, state_nxt;
  logic   hs;
  logic   at_last;

  assign at_last = (count == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    hs        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        hs      = s_valid;
        // Either s_last or running out of addresses closes the frame.
        if (hs && (s_last || at_last)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (state == IDLE && start) begin
        count <= '0;
        err   <= 1'b0;
      end
      if (hs) begin
        wr_en   <= 1'b1;
        wr_addr <= count[AW-1:0];
        wr_data <= s_data;
        count   <= count + ONE;
        // Terminating word: error unless s_last lands exactly on the final address.
        if (s_last || at_last) err <= s_last ^ at_last;
      end
    end
  end

endmodule

// File: tb/tb_weights_save.sv
// Self-checking bench for weights_save: directed frame table, corner sequences, random frames vs a frame-level model.
module tb_weights_save;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW:0]      count;
  logic             busy;
  logic             done;
  logic             err;

  weights_save #(.WIDTH(WIDTH), .ROWS(1), .COLS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .count(count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  logic [WIDTH-1:0] words [0:15];
  int               wq_addr [$];
  logic [WIDTH-1:0] wq_data [$];
  int               done_cnt;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back(wr_data);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one frame; caller is at a negedge. Returns number of words accepted.
  task automatic run_frame(input int nw, input int last_at, input int stall,
                           input bit hold, input bit do_start, output int acc);
    int  i;
    int  cyc;
    bit  take;
    wq_addr.delete();
    wq_data.delete();
    done_cnt = 0;
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
    end
    start = hold;
    chk("busy_at_start", int'(busy), 1);
    chk("count_cleared", int'(count), 0);
    chk("err_cleared", int'(err), 0);
    i = 0;
    cyc = 0;
    while (s_ready && cyc < 300) begin
      take = (i < nw) && !(stall == 1 && cyc % 2 == 1) && !(stall == 2 && $urandom_range(0, 2) == 0);
      if (take) begin
        s_valid = 1'b1;
        s_data  = words[i];
        s_last  = (i == last_at);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (take) i++;
    end
    if (cyc >= 300) chk("frame_timeout", cyc, 0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("done_high", int'(done), 1);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);
    acc = i;
  endtask

  task automatic check_frame(input string nm, input int acc, input int exp_wr, input int exp_err);
    chk($sformatf("%s_accepted", nm), acc, exp_wr);
    chk($sformatf("%s_nwrites", nm), wq_addr.size(), exp_wr);
    for (int k = 0; k < exp_wr && k < wq_addr.size(); k++) begin
      chk($sformatf("%s_addr%0d", nm, k), wq_addr[k], k);
      chk($sformatf("%s_data%0d", nm, k), int'(wq_data[k]), int'(words[k]));
    end
    chk($sformatf("%s_done_cnt", nm), done_cnt, 1);
    chk($sformatf("%s_err", nm), int'(err), exp_err);
    chk($sformatf("%s_count", nm), int'(count), exp_wr);
    if (exp_wr > 0) begin
      chk($sformatf("%s_addr_hold", nm), int'(wr_addr), exp_wr - 1);
      chk($sformatf("%s_data_hold", nm), int'(wr_data), int'(words[exp_wr-1]));
    end
  endtask

  function automatic int model_nwr(input int last_at);
    if (last_at < 0 || last_at >= DEPTH) return DEPTH;
    return last_at + 1;
  endfunction

  typedef struct {
    string nm;
    int    nw;
    int    last_at;
    int    stall;
    int    base;
    int    exp_wr;
    int    exp_err;
  } vec_t;

  vec_t tbl [0:4];

  initial begin
    int acc;
    int nw;
    int r;
    int last_at;

    tbl[0] = '{"normal", 8,  7, 0, 'h10, 8, 0};
    tbl[1] = '{"stall",  8,  7, 1, 'h10, 8, 0};
    tbl[2] = '{"short",  5,  4, 0, 'hA0, 5, 1};
    tbl[3] = '{"long",   9, -1, 0, 'h30, 8, 1};
    tbl[4] = '{"single", 1,  0, 0, 'h55, 1, 1};

    rst_n = 1'b0; start = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    s_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("no_capture_without_start", int'(busy), 0);
    chk("no_write_without_start", wq_addr.size(), 0);
    s_valid = 1'b0;

    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 16; k++) words[k] = WIDTH'(tbl[t].base + k);
      run_frame(tbl[t].nw, tbl[t].last_at, tbl[t].stall, 1'b0, 1'b1, acc);
      check_frame(tbl[t].nm, acc, tbl[t].exp_wr, tbl[t].exp_err);
    end

    // Reset in the middle of a frame.
    for (int k = 0; k < 16; k++) words[k] = WIDTH'(8'h60 + k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = words[k]; s_last = 1'b0;
      @(negedge clk);
    end
    s_data = words[3];
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_s_ready", int'(s_ready), 0);
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_wr_addr", int'(wr_addr), 0);
    chk("midrst_wr_data", int'(wr_data), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_err", int'(err), 0);
    wq_addr.delete();
    wq_data.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_no_writes", wq_addr.size(), 0);
    chk("midrst_stays_idle", int'(busy), 0);
    s_valid = 1'b0;
    for (int k = 0; k < 16; k++) words[k] = WIDTH'(8'h10 + k);
    run_frame(8, 7, 0, 1'b0, 1'b1, acc);
    check_frame("after_rst", acc, 8, 0);

    // Start held through a short frame, then straight into a second frame.
    for (int k = 0; k < 16; k++) words[k] = WIDTH'(8'hC0 + k);
    run_frame(6, 3, 0, 1'b1, 1'b1, acc);
    check_frame("held_first", acc, 4, 1);
    @(negedge clk);
    chk("held_second_busy", int'(busy), 1);
    for (int k = 0; k < 16; k++) words[k] = WIDTH'(8'hD0 + k);
    run_frame(8, 7, 2, 1'b0, 1'b0, acc);
    check_frame("held_second", acc, 8, 0);

    // Random frames against the frame-level model.
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < 16; k++) words[k] = WIDTH'($urandom_range(0, 255));
      nw = $urandom_range(1, DEPTH + 2);
      r  = $urandom_range(0, nw);
      last_at = (r == nw) ? -1 : r;
      if (last_at < 0 && nw < DEPTH) nw = DEPTH + 1;
      if (t % 5 == 0) begin nw = DEPTH; last_at = DEPTH - 1; end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_frame(nw, last_at, ($urandom_range(0, 1) == 1) ? 2 : 0, 1'b0, 1'b1, acc);
      check_frame($sformatf("rnd%0d", t), acc, model_nwr(last_at), (last_at != DEPTH - 1) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
